// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants: FSM state encoding, default frame
// geometry and the mid-bit sample index. PARITY state exists only with UART_RX_PARITY_EN.
package uart_pkg;

   localparam int DATA_BITS_DEF  = 8;
   localparam int OVERSAMPLE_DEF = 16;
   localparam int MID_SAMPLE_DEF = OVERSAMPLE_DEF / 2 - 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } rx_state_t;

   // Sample index, counted from the detected falling edge, that lands in the middle of a bit.
   function automatic int mid_sample(input int oversample);
      return oversample / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module uart_rx_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver with ready/valid output and framing/overrun detection.
// Optional even-parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                 clk_50mhz,
   input  logic                 rst_n,
   input  logic                 rx_clock_enable,
   input  logic                 rx,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_error,
   output logic                 overrun_error,
   output logic                 busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_error
`endif
);

   localparam int SAMPLE_W = $clog2(OVERSAMPLE);
   localparam int BIT_W    = $clog2(DATA_BITS);
   localparam logic [SAMPLE_W-1:0] SAMPLE_MID  = SAMPLE_W'(mid_sample(OVERSAMPLE));
   localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(DATA_BITS - 1);

   rx_state_t            r_state;
   logic [SAMPLE_W-1:0]  r_sample_cnt;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_seen_high;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_framing_error;
   logic                 r_overrun_error;
   logic                 r_busy;
   logic                 w_rx_s;
   logic                 w_sample_pt;
   logic                 w_par_ok;

   uart_rx_sync u_sync (
      .i_clk   (clk_50mhz),
      .i_rst_n (rst_n),
      .i_d     (rx),
      .o_q     (w_rx_s)
   );

   assign w_sample_pt = (r_sample_cnt == SAMPLE_LAST);

`ifdef UART_RX_PARITY_EN
   logic r_par_bad;
   logic r_parity_error;
   assign w_par_ok     = !r_par_bad;
   assign parity_error = r_parity_error;
`else
   assign w_par_ok = 1'b1;
`endif

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_sample_cnt    <= '0;
         r_bit_cnt       <= '0;
         r_shift         <= '0;
         r_seen_high     <= 1'b0;
         r_rx_data       <= '0;
         r_rx_valid      <= 1'b0;
         r_framing_error <= 1'b0;
         r_overrun_error <= 1'b0;
         r_busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad       <= 1'b0;
         r_parity_error  <= 1'b0;
`endif
      end else begin
         r_framing_error <= 1'b0;
         r_overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_error  <= 1'b0;
`endif
         if (r_rx_valid && rx_ready)
            r_rx_valid <= 1'b0;

         if (rx_clock_enable) begin
            case (r_state)
               ST_IDLE: begin
                  // A line that has never been seen high since IDLE is a break, not a start bit.
                  if (w_rx_s) begin
                     r_seen_high <= 1'b1;
                  end else if (r_seen_high) begin
                     r_state      <= ST_START;
                     r_busy       <= 1'b1;
                     r_sample_cnt <= '0;
                     r_bit_cnt    <= '0;
`ifdef UART_RX_PARITY_EN
                     r_par_bad    <= 1'b0;
`endif
                  end
               end

               ST_START: begin
                  if (r_sample_cnt == SAMPLE_MID) begin
                     r_sample_cnt <= '0;
                     if (!w_rx_s) begin
                        r_state <= ST_DATA;
                     end else begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_seen_high <= 1'b0;
                     end
                  end else begin
                     r_sample_cnt <= r_sample_cnt + 1'b1;
                  end
               end

               ST_DATA: begin
                  r_sample_cnt <= w_sample_pt ? '0 : r_sample_cnt + 1'b1;
                  if (w_sample_pt) begin
                     r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                     if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        r_state   <= ST_PARITY;
`else
                        r_state   <= ST_STOP;
`endif
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end
               end

`ifdef UART_RX_PARITY_EN
               ST_PARITY: begin
                  r_sample_cnt <= w_sample_pt ? '0 : r_sample_cnt + 1'b1;
                  if (w_sample_pt) begin
                     r_par_bad      <= (w_rx_s != ^r_shift);
                     r_parity_error <= (w_rx_s != ^r_shift);
                     r_state        <= ST_STOP;
                  end
               end
`endif

               ST_STOP: begin
                  r_sample_cnt <= w_sample_pt ? '0 : r_sample_cnt + 1'b1;
                  if (w_sample_pt) begin
                     r_state     <= ST_IDLE;
                     r_busy      <= 1'b0;
                     r_seen_high <= 1'b0;
                     // A same-cycle consume frees the slot, so the new byte wins over an overrun.
                     if (!w_rx_s) begin
                        r_framing_error <= 1'b1;
                     end else if (w_par_ok) begin
                        if (r_rx_valid && !rx_ready) begin
                           r_overrun_error <= 1'b1;
                        end else begin
                           r_rx_data  <= r_shift;
                           r_rx_valid <= 1'b1;
                        end
                     end
                  end
               end

               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rx_data       = r_rx_data;
   assign rx_valid      = r_rx_valid;
   assign framing_error = r_framing_error;
   assign overrun_error = r_overrun_error;
   assign busy          = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Frame-level bench for uart_receiver: directed scenarios plus randomized frames
// checked against a byte/flag model of the receiver's consumer-visible behaviour.
`timescale 1ns/1ps
module tb_uart_receiver;

   localparam int DIV      = 27;
   localparam int OS       = 16;
   localparam int BIT_CLKS = DIV * OS;

   logic       clk_50mhz = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_clock_enable = 1'b0;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       framing_error;
   logic       overrun_error;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_error;
   int         n_pe = 0;
`endif

   int         n_total = 0;
   int         n_bad = 0;
   int         div_cnt = 0;
   int         n_fe = 0;
   int         n_ov = 0;
   logic [7:0] m_data;
   logic       m_valid;

   uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
      .clk_50mhz       (clk_50mhz),
      .rst_n           (rst_n),
      .rx_clock_enable (rx_clock_enable),
      .rx              (rx),
      .rx_ready        (rx_ready),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .framing_error   (framing_error),
      .overrun_error   (overrun_error),
`ifdef UART_RX_PARITY_EN
      .parity_error    (parity_error),
`endif
      .busy            (busy)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   // Baud generator and error-pulse counters.
   always @(posedge clk_50mhz) begin
      if (div_cnt == DIV - 1) begin
         div_cnt         <= 0;
         rx_clock_enable <= 1'b1;
      end else begin
         div_cnt         <= div_cnt + 1;
         rx_clock_enable <= 1'b0;
      end
      if (framing_error) n_fe <= n_fe + 1;
      if (overrun_error) n_ov <= n_ov + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_error)  n_pe <= n_pe + 1;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(negedge clk_50mhz);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk_50mhz);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(pbit);
`endif
      drive_bit(stop);
   endtask

   task automatic pulse_ready();
      @(negedge clk_50mhz);
      rx_ready = 1'b1;
      @(negedge clk_50mhz);
      rx_ready = 1'b0;
      m_valid  = 1'b0;
      chk("consume_valid", {31'd0, rx_valid}, 32'd0);
   endtask

   // Model: a good frame lands in an empty (or simultaneously emptied) slot,
   // otherwise it overruns; ready held high through the frame drains it at once.
   task automatic run_frame(input string tag, input logic [7:0] d, input logic stop,
                            input logic pflip, input logic ready, input int gap);
      int   fe0, ov0, e_ov;
      logic par_bad;
`ifdef UART_RX_PARITY_EN
      int   pe0;
      pe0 = n_pe;
`endif
      fe0      = n_fe;
      ov0      = n_ov;
      e_ov     = 0;
      par_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  = pflip;
`endif
      rx_ready = ready;
      if (ready) m_valid = 1'b0;
      send_frame(d, stop, (^d) ^ pflip);
      if (gap > 0) idle_bits(gap);
      if (stop && !par_bad) begin
         if (ready) begin
            m_data = d;
         end else if (m_valid) begin
            e_ov = 1;
         end else begin
            m_data  = d;
            m_valid = 1'b1;
         end
      end
      chk({tag, "_valid"}, {31'd0, rx_valid}, {31'd0, m_valid});
      chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, m_data});
      chk({tag, "_fe"}, n_fe - fe0, stop ? 0 : 1);
      chk({tag, "_ov"}, n_ov - ov0, e_ov);
`ifdef UART_RX_PARITY_EN
      chk({tag, "_pe"}, n_pe - pe0, {31'd0, par_bad});
`endif
      rx_ready = 1'b0;
   endtask

   initial begin
      int fe0, ov0;
      bit cleared;
      m_data  = 8'h00;
      m_valid = 1'b0;

      repeat (5) @(negedge clk_50mhz);
      chk("rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_data", {24'd0, rx_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_fe", {31'd0, framing_error}, 32'd0);
      chk("rst_ov", {31'd0, overrun_error}, 32'd0);
      rst_n = 1'b1;
      idle_bits(2);

      // Short low glitch must be rejected without output.
      fe0 = n_fe;
      ov0 = n_ov;
      rx  = 1'b0;
      repeat (4 * DIV) @(negedge clk_50mhz);
      rx = 1'b1;
      chk("glitch_busy_set", {31'd0, busy}, 32'd1);
      cleared = 1'b0;
      for (int i = 0; i < 8 * DIV; i++) begin
         @(negedge clk_50mhz);
         if (!busy) begin
            cleared = 1'b1;
            break;
         end
      end
      chk("glitch_busy_clear", {31'd0, cleared}, 32'd1);
      idle_bits(1);
      chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
      chk("glitch_err", (n_fe - fe0) + (n_ov - ov0), 32'd0);

      // Held byte stays valid until consumed.
      run_frame("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1);
      repeat (1000) @(negedge clk_50mhz);
      chk("a5_hold", {31'd0, rx_valid}, 32'd1);
      pulse_ready();

      run_frame("3c_bad", 8'h3C, 1'b0, 1'b0, 1'b0, 1);
      run_frame("3c_ok", 8'h3C, 1'b1, 1'b0, 1'b0, 1);
      pulse_ready();

      run_frame("b2b_11", 8'h11, 1'b1, 1'b0, 1'b0, 0);
      run_frame("b2b_22", 8'h22, 1'b1, 1'b0, 1'b0, 1);

      // Asynchronous reset in the middle of bit 3 of 0xFF.
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      rx = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk_50mhz);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_err", {30'd0, framing_error, overrun_error}, 32'd0);
      repeat (10) @(negedge clk_50mhz);
      rst_n   = 1'b1;
      m_valid = 1'b0;
      m_data  = 8'h00;
      idle_bits(2);
      chk("post_rst_valid", {31'd0, rx_valid}, 32'd0);
      run_frame("7e", 8'h7E, 1'b1, 1'b0, 1'b0, 1);
      pulse_ready();

`ifdef UART_RX_PARITY_EN
      run_frame("par_bad", 8'h01, 1'b1, 1'b1, 1'b0, 1);
      run_frame("par_ok", 8'h01, 1'b1, 1'b0, 1'b0, 1);
`endif

      for (int k = 0; k < 4; k++) begin
         logic [7:0] d;
         logic       stop, pflip, ready;
         d     = 8'($urandom);
         stop  = ($urandom_range(0, 3) != 0);
         pflip = 1'b0;
`ifdef UART_RX_PARITY_EN
         pflip = ($urandom_range(0, 3) == 0);
`endif
         ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) pulse_ready();
         run_frame($sformatf("rnd%0d", k), d, stop, pflip, ready, 1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
